// File: rtl/daqzilla_pkg.sv
// Shared DAQ definitions: conversion_tx FSM state type and default frame header.
// CHECKSUM state exists only when CONVERSION_TX_CHECKSUM_EN is defined.
package daqzilla_pkg;

    localparam logic [7:0] CONVERSION_TX_HEADER_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
`ifdef CONVERSION_TX_CHECKSUM_EN
        ,
        CHECKSUM = 2'd3
`endif
    } conversion_tx_state_t;

endpackage

// File: rtl/conversion_tx.sv
// Frames a captured conversion word as HEADER, data bytes (MSB first) and an optional
// XOR checksum byte (macro CONVERSION_TX_CHECKSUM_EN) over a valid/ready byte stream.
module conversion_tx
    import daqzilla_pkg::*;
#(
    parameter int unsigned SAMPLE_BYTES = 3,
    parameter logic [7:0]  HEADER_BYTE  = CONVERSION_TX_HEADER_BYTE
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [8*SAMPLE_BYTES-1:0] conversion_data_i,
    input  logic                      byte_ready_i,
    input  logic                      clear_overrun_i,
    output logic [7:0]                byte_o,
    output logic                      byte_valid_o,
    output logic                      busy_o,
    output logic                      overrun_o
);

    localparam int unsigned IDX_W  = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int unsigned WORD_W = 8 * SAMPLE_BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_BYTES - 1);

    conversion_tx_state_t state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [WORD_W-1:0]    word_q;
    logic                 overrun_q;
    logic [7:0]           data_byte;
    logic                 xfer;

    assign xfer         = byte_valid_o & byte_ready_i;
    assign byte_valid_o = (state_q != IDLE);
    assign busy_o       = (state_q != IDLE);
    assign overrun_o    = overrun_q;

    always_comb begin
        data_byte = '0;
        for (int unsigned i = 0; i < SAMPLE_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) data_byte = word_q[WORD_W-8-8*i +: 8];
        end
    end

`ifdef CONVERSION_TX_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = '0;
        for (int unsigned i = 0; i < SAMPLE_BYTES; i++) begin
            checksum = checksum ^ word_q[8*i +: 8];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        byte_o  = '0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = HEADER;
            end
            HEADER: begin
                byte_o = HEADER_BYTE;
                if (xfer) state_d = DATA;
            end
            DATA: begin
                byte_o = data_byte;
                if (xfer && idx_q == LAST_IDX) begin
`ifdef CONVERSION_TX_CHECKSUM_EN
                    state_d = CHECKSUM;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef CONVERSION_TX_CHECKSUM_EN
            CHECKSUM: begin
                byte_o = checksum;
                if (xfer) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) word_q <= conversion_data_i;
            if (state_q == HEADER) begin
                idx_q <= '0;
            end else if (state_q == DATA && xfer) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            // A start while busy always wins over a coincident clear.
            if (start_i && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conversion_tx.sv
// Self-checking bench for conversion_tx; the expected frame is built from the word by a
// byte-queue model (header, MSB-first bytes, optional XOR checksum).
module tb_conversion_tx;

    localparam int unsigned SB  = 3;
    localparam logic [7:0]  HDR = 8'hA5;

    logic              clock_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic              start_i = 1'b0;
    logic [8*SB-1:0]   conversion_data_i = '0;
    logic              byte_ready_i = 1'b0;
    logic              clear_overrun_i = 1'b0;
    logic [7:0]        byte_o;
    logic              byte_valid_o;
    logic              busy_o;
    logic              overrun_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  exp_q[$];

    conversion_tx #(.SAMPLE_BYTES(SB), .HEADER_BYTE(HDR)) dut (
        .clock_i(clock_i),
        .reset_n_i(reset_n_i),
        .start_i(start_i),
        .conversion_data_i(conversion_data_i),
        .byte_ready_i(byte_ready_i),
        .clear_overrun_i(clear_overrun_i),
        .byte_o(byte_o),
        .byte_valid_o(byte_valid_o),
        .busy_o(busy_o),
        .overrun_o(overrun_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_frame(input logic [8*SB-1:0] w);
        logic [7:0]      sum;
        logic [8*SB-1:0] t;
        sum = 8'h00;
        t   = w;
        exp_q.delete();
        exp_q.push_back(HDR);
        for (int i = 0; i < SB; i++) begin
            exp_q.push_back(t[8*SB-1 -: 8]);
            sum = sum ^ t[8*SB-1 -: 8];
            t   = t << 8;
        end
`ifdef CONVERSION_TX_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endfunction

    task automatic begin_frame(input logic [8*SB-1:0] w);
        model_frame(w);
        start_i = 1'b1;
        conversion_data_i = w;
        @(negedge clock_i);
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        byte_ready_i = 1'b1;
        #1;
        n_cmp++; if (byte_o !== 8'h00) begin n_bad++; $display("FAIL reset_byte: got %h want 00", byte_o); end
        n_cmp++; if (byte_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", byte_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        @(negedge clock_i);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clock_i);
    endtask

    task automatic test_basic();
        byte_ready_i = 1'b1;
        begin_frame(24'h123456);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (byte_valid_o !== 1'b1 || byte_o !== exp_q[k]) begin
                n_bad++; $display("FAIL basic_byte%0d: got v=%b %h want v=1 %h", k, byte_valid_o, byte_o, exp_q[k]);
            end
            @(negedge clock_i);
        end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_backpressure();
        byte_ready_i = 1'b1;
        begin_frame(24'h123456);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 2) begin
                repeat (3) begin
                    byte_ready_i = 1'b0;
                    n_cmp++;
                    if (byte_valid_o !== 1'b1 || byte_o !== 8'h34) begin
                        n_bad++; $display("FAIL stall_hold: got v=%b %h want v=1 34", byte_valid_o, byte_o);
                    end
                    @(negedge clock_i);
                end
                byte_ready_i = 1'b1;
            end
            n_cmp++;
            if (byte_valid_o !== 1'b1 || byte_o !== exp_q[k]) begin
                n_bad++; $display("FAIL stall_byte%0d: got v=%b %h want v=1 %h", k, byte_valid_o, byte_o, exp_q[k]);
            end
            @(negedge clock_i);
        end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL stall_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_overrun();
        byte_ready_i = 1'b1;
        begin_frame(24'h123456);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (byte_valid_o !== 1'b1 || byte_o !== exp_q[k]) begin
                n_bad++; $display("FAIL ovr_byte%0d: got v=%b %h want v=1 %h", k, byte_valid_o, byte_o, exp_q[k]);
            end
            if (k == 1) begin
                start_i = 1'b1;
                conversion_data_i = 24'hABCDEF;
            end
            @(negedge clock_i);
            start_i = 1'b0;
            if (k == 1) begin
                n_cmp++; if (overrun_o !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun_o); end
            end
        end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL ovr_busy_end: got %b want 0", busy_o); end
        clear_overrun_i = 1'b1;
        @(negedge clock_i);
        clear_overrun_i = 1'b0;
        n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL ovr_cleared: got %b want 0", overrun_o); end
    endtask

    task automatic test_reset_mid();
        byte_ready_i = 1'b1;
        begin_frame(24'h123456);
        start_i = 1'b1;
        conversion_data_i = 24'h777777;
        @(negedge clock_i);
        start_i = 1'b0;
        @(negedge clock_i);
        n_cmp++;
        if (overrun_o !== 1'b1 || byte_o !== 8'h34) begin
            n_bad++; $display("FAIL rmid_pre: got ovr=%b %h want ovr=1 34", overrun_o, byte_o);
        end
        reset_n_i = 1'b0;
        #1;
        n_cmp++; if (byte_o !== 8'h00) begin n_bad++; $display("FAIL rmid_byte: got %h want 00", byte_o); end
        n_cmp++; if (byte_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", byte_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL rmid_overrun: got %b want 0", overrun_o); end
        @(negedge clock_i);
        reset_n_i = 1'b1;
        repeat (3) @(negedge clock_i);
        n_cmp++; if (byte_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resume: got %b want 0", byte_valid_o); end
        begin_frame(24'h000001);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (byte_valid_o !== 1'b1 || byte_o !== exp_q[k]) begin
                n_bad++; $display("FAIL rmid_byte%0d: got v=%b %h want v=1 %h", k, byte_valid_o, byte_o, exp_q[k]);
            end
            @(negedge clock_i);
        end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_clear_overrun();
        int budget;
        byte_ready_i = 1'b1;
        begin_frame(24'h123456);
        start_i = 1'b1;
        clear_overrun_i = 1'b1;
        conversion_data_i = 24'hFFFFFF;
        @(negedge clock_i);
        start_i = 1'b0;
        n_cmp++; if (overrun_o !== 1'b1) begin n_bad++; $display("FAIL clr_set_wins: got %b want 1", overrun_o); end
        @(negedge clock_i);
        clear_overrun_i = 1'b0;
        n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL clr_alone: got %b want 0", overrun_o); end
        budget = 20;
        while (busy_o === 1'b1 && budget > 0) begin
            @(negedge clock_i);
            budget--;
        end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL clr_drain_timeout: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_final_start();
        byte_ready_i = 1'b1;
        begin_frame(24'hC0FFEE);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (byte_valid_o !== 1'b1 || byte_o !== exp_q[k]) begin
                n_bad++; $display("FAIL fin_byte%0d: got v=%b %h want v=1 %h", k, byte_valid_o, byte_o, exp_q[k]);
            end
            if (k == exp_q.size() - 1) begin
                start_i = 1'b1;
                conversion_data_i = 24'h5A5A5A;
            end
            @(negedge clock_i);
            start_i = 1'b0;
        end
        n_cmp++; if (overrun_o !== 1'b1) begin n_bad++; $display("FAIL fin_overrun: got %b want 1", overrun_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL fin_idle: got busy=%b want 0", busy_o); end
        @(negedge clock_i);
        n_cmp++; if (byte_valid_o !== 1'b0) begin n_bad++; $display("FAIL fin_dropped: got valid=%b want 0", byte_valid_o); end
        clear_overrun_i = 1'b1;
        @(negedge clock_i);
        clear_overrun_i = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            int         k;
            int         budget;
            logic       r;
            logic       stalled;
            logic [7:0] held;
            byte_ready_i = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clock_i);
            begin_frame((8*SB)'($urandom));
            k = 0;
            budget = 200;
            stalled = 1'b0;
            held = 8'h00;
            while (k < exp_q.size() && budget > 0) begin
                r = ($urandom_range(0, 3) != 0);
                byte_ready_i = r;
                if (stalled) begin
                    n_cmp++;
                    if (byte_o !== held) begin n_bad++; $display("FAIL rnd_hold f%0d: got %h want %h", f, byte_o, held); end
                end
                n_cmp++;
                if (byte_valid_o !== 1'b1) begin
                    n_bad++; $display("FAIL rnd_valid f%0d k%0d: got %b want 1", f, k, byte_valid_o);
                end else if (r) begin
                    n_cmp++;
                    if (byte_o !== exp_q[k]) begin n_bad++; $display("FAIL rnd_byte f%0d k%0d: got %h want %h", f, k, byte_o, exp_q[k]); end
                    k++;
                end
                stalled = byte_valid_o && !r;
                held = byte_o;
                @(negedge clock_i);
                budget--;
            end
            n_cmp++;
            if (k != exp_q.size()) begin n_bad++; $display("FAIL rnd_timeout f%0d: got %0d bytes want %0d", f, k, exp_q.size()); end
            n_cmp++;
            if (busy_o !== 1'b0 || overrun_o !== 1'b0) begin
                n_bad++; $display("FAIL rnd_end f%0d: got busy=%b ovr=%b want 0 0", f, busy_o, overrun_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_clear_overrun();
        test_final_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conversion_tx.md
CONVERSION_TX -- requirements
Module: conversion_tx

Interface
REQ-001 The block SHALL have parameter SAMPLE_BYTES, default 3, the number of conversion-data bytes per frame.
REQ-002 The block SHALL have parameter HEADER_BYTE, default 8'hA5, the frame-start byte.
REQ-003 The block SHALL have port clock_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port start_i, input, 1 bit, a one-cycle pulse meaning a new conversion word is available.
REQ-006 The block SHALL have port conversion_data_i, input, 8*SAMPLE_BYTES bits, the conversion word, MSB byte first.
REQ-007 The block SHALL have port byte_ready_i, input, 1 bit, meaning the downstream sink accepts the current byte.
REQ-008 The block SHALL have port clear_overrun_i, input, 1 bit, a synchronous clear of overrun_o.
REQ-009 The block SHALL have port byte_o, output, 8 bits, the outgoing byte.
REQ-010 The block SHALL have port byte_valid_o, output, 1 bit, meaning byte_o holds a valid byte.
REQ-011 The block SHALL have port busy_o, output, 1 bit, high whenever state is not IDLE.
REQ-012 The block SHALL have port overrun_o, output, 1 bit, a sticky flag meaning a conversion was dropped.

Function
REQ-013 The FSM SHALL have states IDLE, HEADER, DATA and CHECKSUM; CHECKSUM exists only per REQ-026.
REQ-014 In IDLE, start_i=1 SHALL capture conversion_data_i into an internal register and go to HEADER on the next edge.
REQ-015 A byte SHALL transfer only in a cycle where byte_valid_o=1 and byte_ready_i=1.
REQ-016 While byte_valid_o=1 and byte_ready_i=0, byte_o SHALL hold stable and byte_valid_o SHALL stay high.
REQ-017 byte_valid_o SHALL be high in HEADER, DATA and CHECKSUM, and low in IDLE.
REQ-018 HEADER SHALL drive HEADER_BYTE; on transfer the FSM SHALL go to DATA with byte index 0.
REQ-019 DATA SHALL drive captured byte [index], index 0 being the MSB byte; each transfer SHALL increment index.
REQ-020 On transfer of index SAMPLE_BYTES-1, DATA SHALL go to CHECKSUM if enabled, otherwise to IDLE.
REQ-021 Latency: for start_i in cycle N, the header SHALL be valid in cycle N+1; with no backpressure, the last byte SHALL transfer in cycle N+1+SAMPLE_BYTES (plus 1 if CHECKSUM is enabled).
REQ-022 start_i in any cycle where state is not IDLE, including the final-transfer cycle, SHALL drop the sample, set overrun_o, and leave the frame in progress unaltered.
REQ-023 If clear_overrun_i and a new overrun occur in the same cycle, overrun_o SHALL be set (set wins).
REQ-024 The captured word SHALL not change between capture and return to IDLE.

Reset
REQ-025 When reset_n_i=0, the block SHALL asynchronously force state=IDLE, index=0, captured word=0, byte_o=0, byte_valid_o=0, busy_o=0 and overrun_o=0; a frame in progress is abandoned, with no resume after release.

Configuration
REQ-026 With macro CONVERSION_TX_CHECKSUM_EN defined, the block SHALL append one CHECKSUM byte after the data bytes, equal to the XOR of all SAMPLE_BYTES data bytes (header excluded); the byte is handshaken like any other.
REQ-027 With CONVERSION_TX_CHECKSUM_EN undefined, the CHECKSUM state and the XOR logic SHALL be absent, and frames SHALL be 1+SAMPLE_BYTES bytes.

Structure
REQ-028 The state enum type conversion_tx_state_t and the default header constant SHALL reside in the shared package daqzilla_pkg.
REQ-029 The block SHALL be a single module with no sub-module; index width SHALL be $clog2(SAMPLE_BYTES) with a minimum of 1.

Verification
REQ-030 The bench SHALL cover: start_i with 24'h123456 and ready tied to 1 -> bytes A5,12,34,56 in cycles N+1..N+4, then busy_o=0; with CHECKSUM enabled -> an additional byte 70 in cycle N+5.
REQ-031 The bench SHALL cover: same start with ready low for 3 cycles on byte 34 -> byte_o stays 34 with valid high for those cycles, and the byte sequence is unchanged.
REQ-032 The bench SHALL cover: second start_i with 24'hABCDEF while sending byte 12 -> overrun_o=1, and the frame still ends with 56 (not EF).
REQ-033 The bench SHALL cover: reset_n_i low mid-DATA -> outputs zero immediately; after release, start with 24'h000001 -> A5,00,00,01.
REQ-034 The bench SHALL cover: clear_overrun_i coincident with a new dropped start -> overrun_o remains 1; clear alone in the next cycle -> overrun_o=0.
REQ-035 The bench SHALL cover: start_i in the cycle of the final byte transfer -> sample dropped, overrun_o=1, and the FSM returns to IDLE.
